// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, resolves exception/eret/branch
// redirects by priority, and parks a branch target while decode is stalled.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [31:0] BrTarget,
    input  logic        ExcReq,
    input  logic        EretReq,
    input  logic [31:0] Epc,
    output logic [31:0] PC,
    output logic        Flush,
    output logic        Pending,
    output logic        FetchExc
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] pend_q, pend_next;
    logic        flush_q, flush_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        pc_next    = pc_q;
        pend_next  = pend_q;
        flush_next = 1'b0;

        if (ExcReq) begin
            pc_next    = EXC_PC;
            state_next = RUN;
            flush_next = 1'b1;
        end else if (EretReq) begin
            pc_next    = Epc;
            state_next = RUN;
            flush_next = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (BrTaken) begin
                        if (Stall) begin
                            pend_next  = BrTarget;
                            state_next = HOLD;
                        end else begin
                            pc_next = BrTarget;
                        end
                    end else if (!Stall) begin
                        pc_next = pc_q + 32'd4;
                    end
                end
                HOLD: begin
                    // First branch wins: any BrTaken seen while parked is dropped.
                    if (!Stall) begin
                        pc_next    = pend_q;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!Reset) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            pend_q  <= pend_next;
            flush_q <= flush_next;
        end
    end

    assign PC       = pc_q;
    assign Flush    = flush_q;
    assign Pending  = (state == HOLD);
    assign FetchExc = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural PC model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        BrTaken = 1'b0;
    logic [31:0] BrTarget = '0;
    logic        ExcReq = 1'b0;
    logic        EretReq = 1'b0;
    logic [31:0] Epc = '0;
    logic [31:0] PC;
    logic        Flush;
    logic        Pending;
    logic        FetchExc;

    pc_sequencer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Stall    (Stall),
        .BrTaken  (BrTaken),
        .BrTarget (BrTarget),
        .ExcReq   (ExcReq),
        .EretReq  (EretReq),
        .Epc      (Epc),
        .PC       (PC),
        .Flush    (Flush),
        .Pending  (Pending),
        .FetchExc (FetchExc)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the fetch address, whether a branch is parked, where
    // it goes, and whether the last edge was an exception/eret redirect.
    logic [31:0] m_pc     = RESET_PC;
    bit          m_parked = 1'b0;
    logic [31:0] m_target = '0;
    bit          m_flush  = 1'b0;
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a < IM_BASE) || (a > IM_LIMIT);
    endfunction

    // Apply one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input bit rst, input bit stall, input bit br, input logic [31:0] tgt,
                        input bit exc, input bit eret, input logic [31:0] epc);
        Reset = rst; Stall = stall; BrTaken = br; BrTarget = tgt;
        ExcReq = exc; EretReq = eret; Epc = epc;
        @(posedge Clk);
        if (!rst) begin
            m_pc = RESET_PC; m_parked = 0; m_target = '0; m_flush = 0;
        end else begin
            m_flush = exc || eret;
            if (exc || eret) begin
                m_pc     = exc ? EXC_PC : epc;
                m_parked = 0;
            end else if (m_parked) begin
                if (!stall) begin m_pc = m_target; m_parked = 0; end
            end else if (br && stall) begin
                m_target = tgt; m_parked = 1;
            end else if (br) begin
                m_pc = tgt;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic free();
        step(1, 0, 0, '0, 0, 0, '0);
    endtask

    always @(negedge Clk) begin
        if (checking) begin
            check("pc", PC, m_pc);
            check("pending", {31'd0, Pending}, {31'd0, m_parked});
            check("flush", {31'd0, Flush}, {31'd0, m_flush});
            check("fetchexc", {31'd0, FetchExc}, {31'd0, addr_fault(m_pc)});
        end
    end

    initial begin
        step(0, 0, 0, '0, 0, 0, '0);
        step(0, 1, 1, 32'h3100, 1, 1, 32'h1);
        checking = 1'b1;
        check("rst_pc", PC, 32'h3000);
        check("rst_flush", {31'd0, Flush}, 32'd0);
        check("rst_pending", {31'd0, Pending}, 32'd0);
        check("rst_fexc", {31'd0, FetchExc}, 32'd0);

        // Sequential fetch after release.
        free(); check("seq1", PC, 32'h3004);
        free(); check("seq2", PC, 32'h3008);
        free(); check("seq3", PC, 32'h300C);
        free(); check("seq4", PC, 32'h3010);

        // Stalled branch parks; the second target is ignored.
        step(1, 1, 1, 32'h3100, 0, 0, '0);
        check("hold_pc", PC, 32'h3010); check("hold_pend", {31'd0, Pending}, 32'd1);
        step(1, 1, 1, 32'h3200, 0, 0, '0);
        check("hold_pc2", PC, 32'h3010);
        step(1, 0, 0, '0, 0, 0, '0);
        check("br_pc", PC, 32'h3100); check("br_pend", {31'd0, Pending}, 32'd0);
        free(); check("br_next", PC, 32'h3104);

        // Release with a simultaneous branch: the parked target wins.
        step(1, 1, 1, 32'h3500, 0, 0, '0);
        step(1, 0, 1, 32'h3600, 0, 0, '0);
        check("rel_drop", PC, 32'h3500);

        // Exception while parked.
        step(1, 1, 1, 32'h3300, 0, 0, '0);
        step(1, 1, 0, '0, 1, 0, '0);
        check("exc_pc", PC, 32'h4180); check("exc_pend", {31'd0, Pending}, 32'd0);
        check("exc_flush", {31'd0, Flush}, 32'd1);
        free(); check("exc_next", PC, 32'h4184); check("exc_flush0", {31'd0, Flush}, 32'd0);

        // Exception beats eret, then eret alone; Flush on both cycles.
        step(1, 0, 0, '0, 1, 1, 32'h3020);
        check("pri_pc", PC, 32'h4180); check("pri_flush", {31'd0, Flush}, 32'd1);
        step(1, 0, 0, '0, 0, 1, 32'h3020);
        check("eret_pc", PC, 32'h3020); check("eret_flush", {31'd0, Flush}, 32'd1);
        free(); check("eret_next", PC, 32'h3024);

        // Faulting fetch addresses are loaded unmodified.
        step(1, 0, 0, '0, 0, 1, 32'h3002);
        check("mis_pc", PC, 32'h3002); check("mis_fexc", {31'd0, FetchExc}, 32'd1);
        free(); check("mis_next", PC, 32'h3006);
        step(1, 0, 1, 32'h7000, 0, 0, '0);
        check("oor_pc", PC, 32'h7000); check("oor_fexc", {31'd0, FetchExc}, 32'd1);
        free(); check("oor_next", PC, 32'h7004);
        step(1, 0, 1, 32'h6FFC, 0, 0, '0);
        check("lim_fexc", {31'd0, FetchExc}, 32'd0);
        step(1, 0, 0, '0, 0, 1, 32'hFFFF_FFFC);
        free(); check("wrap_pc", PC, 32'h0000_0000);

        // Reset while parked abandons the target.
        step(1, 1, 1, 32'h3400, 0, 0, '0);
        step(0, 1, 1, 32'h3400, 0, 0, '0);
        check("rsth_pc", PC, 32'h3000); check("rsth_pend", {31'd0, Pending}, 32'd0);
        free(); check("rsth_next", PC, 32'h3004);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t, e;
            t = ($urandom_range(0, 7) == 0) ? $urandom() : (IM_BASE + ($urandom_range(0, 16'h0FFF) << 2));
            e = ($urandom_range(0, 7) == 0) ? $urandom() : (IM_BASE + ($urandom_range(0, 16'h0FFF) << 2));
            step($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, t,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, e);
        end

        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
